// File: rtl/fifo_pkg.sv
// Shared defaults for the sync FIFO and its read-side stream adapter.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH = 16;

    // Occupancy of the two-slot (head + skid) output buffer.
    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

endpackage

// File: rtl/fifo_rd_stream.sv
// Converts a combinational-read sync FIFO interface into a valid/ready
// stream. A head slot drives m_data straight from a register and a skid
// slot absorbs the word popped while the head is stalled, so fifo_pop never
// has to look at m_ready.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_pop,
    input  logic             flush,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    occ_t             occ;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             beat;

    // Pop whenever there is room; rst_n gates it so no pop escapes during reset.
    always_comb begin
        fifo_pop = rst_n && !fifo_empty && (occ != OCC_2) && !flush;
        beat     = (occ != OCC_0) && m_ready && !flush;
    end

    assign m_valid = (occ != OCC_0);
    assign m_data  = head;

    // Slot/occupancy update: occ tracks occ + pop - beat, flush empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= OCC_0;
            head <= '0;
            skid <= '0;
        end else if (flush) begin
            occ <= OCC_0;
        end else begin
            unique case (occ)
                OCC_0: begin
                    if (fifo_pop) begin
                        head <= fifo_rd_data;
                        occ  <= OCC_1;
                    end
                end
                OCC_1: begin
                    if (fifo_pop && beat) begin
                        head <= fifo_rd_data;
                    end else if (fifo_pop) begin
                        skid <= fifo_rd_data;
                        occ  <= OCC_2;
                    end else if (beat) begin
                        occ <= OCC_0;
                    end
                end
                OCC_2: begin
                    // No pop is possible here, so only the skid-to-head move remains.
                    if (beat) begin
                        head <= skid;
                        occ  <= OCC_1;
                    end
                end
                default: occ <= OCC_0;
            endcase
        end
    end

    // Accepted-beat counter; wraps naturally and survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_ONE;
        end
    end

endmodule
